// File: rtl/lsu_pkg.sv
// Shared Funct3 encodings, FSM state type and size decode for the load/store alignment unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Access size in bytes; Funct3[2] (unsigned) never changes the size.
  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    logic [2:0] sz;
    case (f3_lo)
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed bytes out of the two-word window {hi,lo} and sign/zero-extends them.
// Only the low 24 bits of the high word can ever land in a 32-bit result.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [23:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] rd_o
);

  logic [31:0] win_s;

  // Byte-granular right shift of the window by the address offset.
  always_comb begin
    case (off_i)
      2'd0:    win_s = lo_i;
      2'd1:    win_s = {hi_i[7:0],  lo_i[31:8]};
      2'd2:    win_s = {hi_i[15:0], lo_i[31:16]};
      default: win_s = {hi_i[23:0], lo_i[31:24]};
    endcase
  end

  // Extension by access type.
  always_comb begin
    case (f3_i)
      F3_B:    rd_o = {{24{win_s[7]}}, win_s[7:0]};
      F3_H:    rd_o = {{16{win_s[15]}}, win_s[15:0]};
      F3_W:    rd_o = win_s;
      F3_BU:   rd_o = {24'h000000, win_s[7:0]};
      F3_HU:   rd_o = {16'h0000, win_s[15:0]};
      default: rd_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between EX/MEM and a word-organised data memory.
// Define LSU_MISALIGNED_SPLIT_EN to perform word-crossing accesses as two beats instead of faulting.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  access_err,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int WA_W = DM_ADDRESS - 2;

  lsu_state_t        state_q;
  logic              req_ready_q, rsp_valid_q, err_q, is_load_q;
  logic              mem_re_q, mem_we_q;
  logic [3:0]        mem_be_q;
  logic [WA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic [1:0]        off_d;
  logic [2:0]        size_d;
  logic [3:0]        lanes_d, be0_d;
  logic              cross_d, illegal_d, err_d;
  logic [DATA_W-1:0] wdata0_d;
  logic [DATA_W-1:0] lo_word_s, ext_rd_s;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [WA_W-1:0]   addr1_q;
  logic [3:0]        be1_q;
  logic [DATA_W-1:0] wdata1_q, lo_q;
  logic [7:0]        lanes_wide_d;
  logic [2*DATA_W-1:0] wd_wide_d;
  logic [3:0]        be1_d;
  logic [DATA_W-1:0] wdata1_d;
`endif

  // Request decode: legality, word crossing and lane placement of both beats.
  always_comb begin
    off_d  = a[1:0];
    size_d = size_bytes(Funct3[1:0]);
    case (size_d)
      3'd1:    lanes_d = 4'b0001;
      3'd2:    lanes_d = 4'b0011;
      default: lanes_d = 4'b1111;
    endcase
    cross_d = ((size_d == 3'd4) && (off_d != 2'd0)) || ((size_d == 3'd2) && (off_d == 2'd3));
    if (MemRead) begin
      case (Funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_d = 1'b0;
        default:                        illegal_d = 1'b1;
      endcase
    end else begin
      case (Funct3)
        F3_B, F3_H, F3_W: illegal_d = 1'b0;
        default:          illegal_d = 1'b1;
      endcase
    end
`ifdef LSU_MISALIGNED_SPLIT_EN
    lanes_wide_d = {4'b0000, lanes_d} << off_d;
    wd_wide_d    = {{DATA_W{1'b0}}, wd} << {off_d, 3'b000};
    be0_d        = lanes_wide_d[3:0];
    be1_d        = lanes_wide_d[7:4];
    wdata0_d     = wd_wide_d[DATA_W-1:0];
    wdata1_d     = wd_wide_d[2*DATA_W-1:DATA_W];
    err_d        = illegal_d;
`else
    be0_d    = lanes_d << off_d;
    wdata0_d = wd << {off_d, 3'b000};
    err_d    = illegal_d | cross_d;
`endif
  end

  // Control FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      is_load_q   <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= {WA_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q  <= 1'b0;
      addr1_q  <= {WA_W{1'b0}};
      be1_q    <= 4'b0000;
      wdata1_q <= {DATA_W{1'b0}};
      lo_q     <= {DATA_W{1'b0}};
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= {WA_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      case (state_q)
        IDLE: begin
          if (req_valid && (MemRead || MemWrite)) begin
            req_ready_q <= 1'b0;
            is_load_q   <= MemRead;
            f3_q        <= Funct3;
            off_q       <= off_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q  <= cross_d;
            addr1_q  <= a[DM_ADDRESS-1:2] + WA_W'(1);
            be1_q    <= be1_d;
            wdata1_q <= wdata1_d;
`endif
            if (err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
            end else begin
              state_q     <= ACC0;
              mem_addr_q  <= a[DM_ADDRESS-1:2];
              mem_re_q    <= MemRead;
              mem_we_q    <= ~MemRead;
              mem_be_q    <= MemRead ? 4'b0000 : be0_d;
              mem_wdata_q <= MemRead ? {DATA_W{1'b0}} : wdata0_d;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_q) begin
            state_q     <= ACC1;
            mem_addr_q  <= addr1_q;
            mem_re_q    <= is_load_q;
            mem_we_q    <= ~is_load_q;
            mem_be_q    <= is_load_q ? 4'b0000 : be1_q;
            mem_wdata_q <= is_load_q ? {DATA_W{1'b0}} : wdata1_q;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
`else
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
`endif
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: begin
          lo_q        <= mem_rdata;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
`endif
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          err_q       <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          err_q       <= 1'b0;
        end
      endcase
    end
  end

  // Low word of the load window: buffered beat0 for split loads, otherwise the single returned word.
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign lo_word_s = split_q ? lo_q : mem_rdata;
`else
  assign lo_word_s = mem_rdata;
`endif

  lsu_load_extract u_extract (
    .hi_i  (mem_rdata[23:0]),
    .lo_i  (lo_word_s),
    .off_i (off_q),
    .f3_i  (f3_q),
    .rd_o  (ext_rd_s)
  );

  assign rd         = ((state_q == RESP) && is_load_q && !err_q) ? ext_rd_s : {DATA_W{1'b0}};
  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign access_err = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed, table-driven bench for lsu_align with a simple word memory model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd, rd, mem_wdata, mem_rdata;
  logic        rsp_valid, access_err, mem_re, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_align dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .a(a), .wd(wd),
    .rsp_valid(rsp_valid), .rd(rd), .access_err(access_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  bit [31:0] dmem [128];

  // Word memory: byte-lane writes, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        r, w;
    logic [2:0]  f3;
    logic [8:0]  ad;
    logic [31:0] d, lat, err, erd, nb, a0, be0, wd0, a1, be1, wd1;
  } vec_t;

  function automatic vec_t mk(input string n, input logic r, input logic w, input logic [2:0] f3,
                              input logic [8:0] ad, input logic [31:0] d, input logic [31:0] lat,
                              input logic [31:0] err, input logic [31:0] erd, input logic [31:0] nb,
                              input logic [31:0] a0, input logic [31:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [31:0] be1, input logic [31:0] wd1);
    vec_t v;
    v.name = n; v.r = r; v.w = w; v.f3 = f3; v.ad = ad; v.d = d;
    v.lat = lat; v.err = err; v.erd = erd; v.nb = nb;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    return v;
  endfunction

  // Observations of the last operation.
  int          o_lat, o_nb;
  logic [31:0] o_rd, o_err, o_busy_ready;
  logic [31:0] b_addr[2], b_be[2], b_wd[2], b_re[2], b_we[2];

  task automatic run_op(input logic r, input logic w, input logic [2:0] f, input logic [8:0] ad,
                        input logic [31:0] d);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = r; MemWrite = w; Funct3 = f; a = ad; wd = d;
    o_lat = -1; o_nb = 0; o_rd = 32'h0; o_err = 32'h0; o_busy_ready = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o_busy_ready = 32'(req_ready);
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b111; a = 9'h155; wd = 32'hA5A5A5A5;
      end
      if (mem_re || mem_we) begin
        if (o_nb < 2) begin
          b_addr[o_nb] = 32'(mem_addr); b_be[o_nb] = 32'(mem_be); b_wd[o_nb] = mem_wdata;
          b_re[o_nb] = 32'(mem_re); b_we[o_nb] = 32'(mem_we);
        end
        o_nb++;
      end
      if (rsp_valid) begin
        o_lat = k; o_rd = rd; o_err = 32'(access_err);
        break;
      end
    end
  endtask

  vec_t vecs[$];
  vec_t v;
  logic quiet;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; a = 9'h000; wd = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_access_err", 32'(access_err), 32'd0);
    check("rst_mem_ctl", {25'd0, mem_re, mem_we, mem_be, 1'b0}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    //                 name        r     w     f3      a       wd           lat err rd            nb a0    be0  wd0           a1    be1  wd1
    vecs.push_back(mk("sw_010",    1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 2, 0, 0,            1, 7'h04, 4'hF, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk("lw_010",    1'b1, 1'b0, 3'b010, 9'h010, 0,            2, 0, 32'hDEADBEEF, 1, 7'h04, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("sb_013",    1'b0, 1'b1, 3'b000, 9'h013, 32'h000000A5, 2, 0, 0,            1, 7'h04, 4'h8, 32'hA5000000, 0, 0, 0));
    vecs.push_back(mk("lb_013",    1'b1, 1'b0, 3'b000, 9'h013, 0,            2, 0, 32'hFFFFFFA5, 1, 7'h04, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lbu_013",   1'b1, 1'b0, 3'b100, 9'h013, 0,            2, 0, 32'h000000A5, 1, 7'h04, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("sw_020",    1'b0, 1'b1, 3'b010, 9'h020, 32'h12F08034, 2, 0, 0,            1, 7'h08, 4'hF, 32'h12F08034, 0, 0, 0));
    vecs.push_back(mk("lh_021",    1'b1, 1'b0, 3'b001, 9'h021, 0,            2, 0, 32'hFFFFF080, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lhu_021",   1'b1, 1'b0, 3'b101, 9'h021, 0,            2, 0, 32'h0000F080, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lh_022",    1'b1, 1'b0, 3'b001, 9'h022, 0,            2, 0, 32'h000012F0, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lb_020",    1'b1, 1'b0, 3'b000, 9'h020, 0,            2, 0, 32'h00000034, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lb_021",    1'b1, 1'b0, 3'b000, 9'h021, 0,            2, 0, 32'hFFFFFF80, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("sh_022",    1'b0, 1'b1, 3'b001, 9'h022, 32'h0000BEEF, 2, 0, 0,            1, 7'h08, 4'hC, 32'hBEEF0000, 0, 0, 0));
    vecs.push_back(mk("lw_020",    1'b1, 1'b0, 3'b010, 9'h020, 0,            2, 0, 32'hBEEF8034, 1, 7'h08, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("sw_0fc",    1'b0, 1'b1, 3'b010, 9'h0FC, 32'hAABBCCDD, 2, 0, 0,            1, 7'h3F, 4'hF, 32'hAABBCCDD, 0, 0, 0));
    vecs.push_back(mk("sw_100",    1'b0, 1'b1, 3'b010, 9'h100, 32'h11223344, 2, 0, 0,            1, 7'h40, 4'hF, 32'h11223344, 0, 0, 0));
`ifdef LSU_MISALIGNED_SPLIT_EN
    vecs.push_back(mk("lw_0fe",    1'b1, 1'b0, 3'b010, 9'h0FE, 0,            3, 0, 32'h3344AABB, 2, 7'h3F, 4'h0, 0,            7'h40, 4'h0, 0));
    vecs.push_back(mk("lh_0ff",    1'b1, 1'b0, 3'b001, 9'h0FF, 0,            3, 0, 32'h000044AA, 2, 7'h3F, 4'h0, 0,            7'h40, 4'h0, 0));
    vecs.push_back(mk("sw_1ff",    1'b0, 1'b1, 3'b010, 9'h1FF, 32'h44332211, 3, 0, 0,            2, 7'h7F, 4'h8, 32'h11000000, 7'h00, 4'h7, 32'h00443322));
    vecs.push_back(mk("lw_000",    1'b1, 1'b0, 3'b010, 9'h000, 0,            2, 0, 32'h00443322, 1, 7'h00, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lbu_1ff",   1'b1, 1'b0, 3'b100, 9'h1FF, 0,            2, 0, 32'h00000011, 1, 7'h7F, 4'h0, 0,            0, 0, 0));
`else
    vecs.push_back(mk("lw_0fe",    1'b1, 1'b0, 3'b010, 9'h0FE, 0,            1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lh_0ff",    1'b1, 1'b0, 3'b001, 9'h0FF, 0,            1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sw_1ff",    1'b0, 1'b1, 3'b010, 9'h1FF, 32'h44332211, 1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk("lw_f3_011", 1'b1, 1'b0, 3'b011, 9'h010, 0,            1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw_f3_111", 1'b1, 1'b0, 3'b111, 9'h010, 0,            1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("st_f3_100", 1'b0, 1'b1, 3'b100, 9'h010, 32'h12345678, 1, 1, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_and_wr", 1'b1, 1'b1, 3'b010, 9'h010, 32'h12345678, 2, 0, 32'hA5ADBEEF, 1, 7'h04, 4'h0, 0,            0, 0, 0));
    vecs.push_back(mk("lw_010_b",  1'b1, 1'b0, 3'b010, 9'h010, 0,            2, 0, 32'hA5ADBEEF, 1, 7'h04, 4'h0, 0,            0, 0, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.r, v.w, v.f3, v.ad, v.d);
      check({v.name, ".busy_ready"}, o_busy_ready, 32'd0);
      check({v.name, ".latency"}, 32'(o_lat), v.lat);
      check({v.name, ".access_err"}, o_err, v.err);
      if (v.r || v.err != 32'd0) check({v.name, ".rd"}, o_rd, v.erd);
      check({v.name, ".beats"}, 32'(o_nb), v.nb);
      if (o_nb >= 1 && v.nb >= 32'd1) begin
        check({v.name, ".b0_addr"}, b_addr[0], v.a0);
        check({v.name, ".b0_be"}, b_be[0], v.be0);
        check({v.name, ".b0_re_we"}, {b_re[0][15:0], b_we[0][15:0]}, {15'd0, v.r, 15'd0, ~v.r});
        if (!v.r) check({v.name, ".b0_wdata"}, b_wd[0], v.wd0);
      end
      if (o_nb >= 2 && v.nb >= 32'd2) begin
        check({v.name, ".b1_addr"}, b_addr[1], v.a1);
        check({v.name, ".b1_be"}, b_be[1], v.be1);
        check({v.name, ".b1_re_we"}, {b_re[1][15:0], b_we[1][15:0]}, {15'd0, v.r, 15'd0, ~v.r});
        if (!v.r) check({v.name, ".b1_wdata"}, b_wd[1], v.wd1);
      end
    end

    // req_valid with neither strobe must be ignored.
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010; a = 9'h010;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!req_ready || mem_re || mem_we || rsp_valid) quiet = 1'b0;
    end
    check("no_strobe_ignored", 32'(quiet), 32'd1);
    req_valid = 1'b0;

    // Reset while the first store beat is on the bus.
    @(negedge clk);
    check("rst_seq_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010;
`ifdef LSU_MISALIGNED_SPLIT_EN
    a = 9'h1FF; wd = 32'hDDCCBBAA;
`else
    a = 9'h030; wd = 32'h5A5A5A5A;
`endif
    @(negedge clk);
    req_valid = 1'b0; MemWrite = 1'b0;
    check("rst_seq_acc0_we", 32'(mem_we), 32'd1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("rst_seq_acc0_be", 32'(mem_be), 32'h8);
`else
    check("rst_seq_acc0_be", 32'(mem_be), 32'hF);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_ready_after", 32'(req_ready), 32'd1);
    check("rst_seq_we_after", 32'(mem_we), 32'd0);
    check("rst_seq_rsp_after", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we || mem_re || rsp_valid || !req_ready) quiet = 1'b0;
    end
    check("rst_seq_no_resume", 32'(quiet), 32'd1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    run_op(1'b1, 1'b0, 3'b010, 9'h000, 32'h0);
    check("rst_seq_beat1_dropped", o_rd, 32'h00443322);
    run_op(1'b1, 1'b0, 3'b100, 9'h1FF, 32'h0);
    check("rst_seq_beat0_landed", o_rd, 32'h000000AA);
`else
    run_op(1'b1, 1'b0, 3'b010, 9'h030, 32'h0);
    check("rst_seq_beat0_landed", o_rd, 32'h5A5A5A5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
